// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the two-source FIFO drain controller:
// FSM state encoding and source index constants.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/fifo_rr_drain_if.sv
// Bus between the drain controller, its two FIFOs and the byte sink.
// Handshake: a word moves on OUT_* when OUT_VALID and OUT_READY are both 1
// at a rising edge; OUT_DATA/OUT_SRC hold steady while OUT_VALID is 1.
// RENx is a one-cycle read strobe; RDAT_ENx marks RDATx valid one cycle later.
interface fifo_rr_drain_if #(parameter int data_width = 8);

    logic                  EMPTY0;
    logic                  REN0;
    logic [data_width-1:0] RDAT0;
    logic                  RDAT_EN0;
    logic                  EMPTY1;
    logic                  REN1;
    logic [data_width-1:0] RDAT1;
    logic                  RDAT_EN1;
    logic                  OUT_VALID;
    logic [data_width-1:0] OUT_DATA;
    logic                  OUT_SRC;
    logic                  OUT_READY;

    // Controller side
    modport master (
        input  EMPTY0, RDAT0, RDAT_EN0,
        input  EMPTY1, RDAT1, RDAT_EN1,
        input  OUT_READY,
        output REN0, REN1,
        output OUT_VALID, OUT_DATA, OUT_SRC
    );

    // FIFO and sink side
    modport slave (
        output EMPTY0, RDAT0, RDAT_EN0,
        output EMPTY1, RDAT1, RDAT_EN1,
        output OUT_READY,
        input  REN0, REN1,
        input  OUT_VALID, OUT_DATA, OUT_SRC
    );

endinterface

// File: rtl/fifo_rr_drain_rr_grant2.sv
// Two-source grant decision with per-source burst limit.
// Build option FIFO_STRICT_PRIO_EN: source 0 always wins, burst count held at 0.
module rr_grant2
    import fifo_ctrl_pkg::*;
#(
    parameter int burst_max = 4,
    parameter int cnt_width = 8
) (
    input  logic                 empty0_i,
    input  logic                 empty1_i,
    input  logic                 last_i,
    input  logic [cnt_width-1:0] cnt_i,
    output logic                 req_o,
    output logic                 grant_o,
    output logic [cnt_width-1:0] cnt_o
);

    localparam logic [cnt_width-1:0] BMAX = cnt_width'(burst_max);
    localparam logic [cnt_width-1:0] ONE  = cnt_width'(1);

`ifdef FIFO_STRICT_PRIO_EN
    logic unused_rr;
    assign unused_rr = ^{last_i, cnt_i, BMAX, ONE};

    // Fixed priority: source 0 whenever it has data
    always_comb begin
        req_o   = ~empty0_i | ~empty1_i;
        grant_o = empty0_i ? SRC1 : SRC0;
        cnt_o   = '0;
    end
`else
    // Round-robin with burst limit. A count of 0 only occurs after reset and
    // means no burst is running, so the pointer hands the grant to the other
    // source (last=1 after reset, hence source 0 wins first).
    always_comb begin
        req_o   = ~empty0_i | ~empty1_i;
        grant_o = last_i;
        cnt_o   = cnt_i;
        if (empty0_i) begin
            grant_o = SRC1;
        end else if (empty1_i) begin
            grant_o = SRC0;
        end else if ((cnt_i != '0) && (cnt_i < BMAX)) begin
            grant_o = last_i;
        end else begin
            grant_o = ~last_i;
        end
        if (grant_o == last_i) begin
            cnt_o = (cnt_i >= BMAX) ? BMAX : (cnt_i + ONE);
        end else begin
            cnt_o = ONE;
        end
    end
`endif

endmodule

// File: rtl/fifo_rr_drain.sv
// Drain controller for two FIFOs sharing one byte sink: picks a source,
// strobes its read, captures the returned word and offers it with a tag.
// Build option FIFO_STRICT_PRIO_EN selects fixed priority for source 0.
module fifo_rr_drain
    import fifo_ctrl_pkg::*;
#(
    parameter int data_width = 8,
    parameter int burst_max  = 4,
    parameter int cnt_width  = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    fifo_rr_drain_if.master      bus,
    output logic                 BUSY,
    output state_t               DBG_STATE
);

    state_t                state_q, state_d;
    logic                  last_q, last_d;      // source of the current/last grant
    logic [cnt_width-1:0]  cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [data_width-1:0] out_data_q, out_data_d;
    logic                  out_src_q, out_src_d;

    logic                  arb_req;
    logic                  arb_grant;
    logic [cnt_width-1:0]  arb_cnt;

    rr_grant2 #(
        .burst_max (burst_max),
        .cnt_width (cnt_width)
    ) u_grant (
        .empty0_i (bus.EMPTY0),
        .empty1_i (bus.EMPTY1),
        .last_i   (last_q),
        .cnt_i    (cnt_q),
        .req_o    (arb_req),
        .grant_o  (arb_grant),
        .cnt_o    (arb_cnt)
    );

    // State register and output word register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            last_q      <= SRC1;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    // Next-state: grant at IDLE, strobe at ISSUE, capture, then hold for the sink
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        case (state_q)
            S_IDLE: begin
                if (arb_req) begin
                    last_d  = arb_grant;
                    cnt_d   = arb_cnt;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // A read the FIFO gated off returns no data; drop back to IDLE
                if ((last_q == SRC1) ? bus.RDAT_EN1 : bus.RDAT_EN0) begin
                    out_data_d  = (last_q == SRC1) ? bus.RDAT1 : bus.RDAT0;
                    out_src_d   = last_q;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (bus.OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.REN0      = (state_q == S_ISSUE) && (last_q == SRC0);
    assign bus.REN1      = (state_q == S_ISSUE) && (last_q == SRC1);
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_SRC   = out_src_q;
    assign BUSY          = (state_q != S_IDLE);
    assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: two behavioural FIFOs, a queue-based arbitration
// model and a scoreboard of expected {src, data} words.
module tb_fifo_rr_drain;
    import fifo_ctrl_pkg::*;

    localparam int DW    = 8;
    localparam int BURST = 4;

    logic   CLK = 1'b0;
    logic   RESET = 1'b1;
    logic   BUSY;
    state_t dbg_state;

    fifo_rr_drain_if #(.data_width(DW)) bus();

    fifo_rr_drain #(
        .data_width (DW),
        .burst_max  (BURST),
        .cnt_width  (8)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .bus       (bus),
        .BUSY      (BUSY),
        .DBG_STATE (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- behavioural FIFOs ----------------
    logic [DW-1:0] mem0 [64];
    logic [DW-1:0] mem1 [64];
    int            wr0 = 0, wr1 = 0;
    int            rd0 = 0, rd1 = 0;
    logic [DW-1:0] rq0 = '0, rq1 = '0;
    logic          fen0 = 1'b0, fen1 = 1'b0;
    logic          gate0 = 1'b0;

    assign bus.EMPTY0   = (wr0 == rd0);
    assign bus.EMPTY1   = (wr1 == rd1);
    assign bus.RDAT0    = rq0;
    assign bus.RDAT1    = rq1;
    assign bus.RDAT_EN0 = fen0 & ~gate0;
    assign bus.RDAT_EN1 = fen1;

    always @(posedge CLK) begin
        fen0 <= 1'b0;
        fen1 <= 1'b0;
        if (bus.REN0 && (wr0 != rd0)) begin
            rq0  <= mem0[rd0 % 64];
            rd0  <= rd0 + 1;
            fen0 <= 1'b1;
        end
        if (bus.REN1 && (wr1 != rd1)) begin
            rq1  <= mem1[rd1 % 64];
            rd1  <= rd1 + 1;
            fen1 <= 1'b1;
        end
    end

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int fails  = 0;
    logic [DW:0]   exp_q[$];         // {src, data}
    logic [DW-1:0] m0[$], m1[$];     // words the model has not granted yet
    bit            mlast = 1'b1;
    int            mcnt  = 0;
    int            ren0_cnt = 0, ren1_cnt = 0;
    bit            prev_ren0 = 0, prev_ren1 = 0;
    logic          snap_valid = 1'b0;
    logic [DW-1:0] snap_data = '0;
    logic          snap_src = 1'b0;
    logic          obs_src[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration from the rules: returns the source that gets the next read
    function automatic bit model_grant();
        bit n0, n1, g;
        n0 = (m0.size() > 0);
        n1 = (m1.size() > 0);
`ifdef FIFO_STRICT_PRIO_EN
        g = n0 ? 1'b0 : 1'b1;
        mcnt = 0;
`else
        if (!n0)                          g = 1'b1;
        else if (!n1)                     g = 1'b0;
        else if (mcnt > 0 && mcnt < BURST) g = mlast;
        else                              g = ~mlast;
        if (g == mlast) mcnt = (mcnt + 1 > BURST) ? BURST : mcnt + 1;
        else            mcnt = 1;
`endif
        mlast = g;
        return g;
    endfunction

    function automatic logic [DW-1:0] model_pop(input bit g);
        return g ? m1.pop_front() : m0.pop_front();
    endfunction

    // Everything loaded so far drains in model order
    task automatic model_drain();
        bit g;
        while (m0.size() > 0 || m1.size() > 0) begin
            g = model_grant();
            exp_q.push_back({g, model_pop(g)});
        end
    endtask

    task automatic push(input bit src, input logic [DW-1:0] d);
        if (src) begin
            mem1[wr1 % 64] = d; wr1++; m1.push_back(d);
        end else begin
            mem0[wr0 % 64] = d; wr0++; m0.push_back(d);
        end
    endtask

    // One cycle: wait for the falling edge, score what happened at the last
    // rising edge, check strobe rules, then snapshot outputs for next time.
    task automatic tick();
        logic [DW:0] e;
        @(negedge CLK);
        if (snap_valid && !RESET && bus.OUT_READY) begin
            obs_src.push_back(snap_src);
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {23'd0, snap_src, snap_data}, 32'h1ff);
            end else begin
                e = exp_q.pop_front();
                chk("out_word", {23'd0, snap_src, snap_data}, {23'd0, e});
            end
        end else if (snap_valid && !RESET) begin
            chk("hold_valid", 32'(bus.OUT_VALID), 32'd1);
            chk("hold_word", {23'd0, bus.OUT_SRC, bus.OUT_DATA}, {23'd0, snap_src, snap_data});
        end
        chk("ren_exclusive", 32'(bus.REN0 & bus.REN1), 32'd0);
        if (bus.REN0) begin
            chk("ren0_nonempty", 32'(bus.EMPTY0), 32'd0);
            chk("ren0_single", 32'(prev_ren0), 32'd0);
            ren0_cnt++;
        end
        if (bus.REN1) begin
            chk("ren1_nonempty", 32'(bus.EMPTY1), 32'd0);
            chk("ren1_single", 32'(prev_ren1), 32'd0);
            ren1_cnt++;
        end
        prev_ren0  = bus.REN0;
        prev_ren1  = bus.REN1;
        snap_valid = bus.OUT_VALID;
        snap_data  = bus.OUT_DATA;
        snap_src   = bus.OUT_SRC;
    endtask

    task automatic wait_idle(input string tag, input int limit, input bit rnd);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            tick();
            if (rnd) bus.OUT_READY = ($urandom_range(0, 3) != 0);
            done = (exp_q.size() == 0) && !BUSY && (wr0 == rd0) && (wr1 == rd1);
        end
        bus.OUT_READY = 1'b1;
        checks++;
        assert (done === 1'b1) else begin
            fails++;
            $error("FAIL %s_timeout observed=busy%0d/pending%0d expected=idle/0", tag, BUSY, exp_q.size());
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int r0, r1, n0, n1;
        bit found, g;
        logic [11:0] order, exp_order;

        bus.OUT_READY = 1'b1;
        RESET = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_data", 32'(bus.OUT_DATA), 32'd0);
        chk("rst_src", 32'(bus.OUT_SRC), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_ren", {30'd0, bus.REN1, bus.REN0}, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        RESET = 1'b0;
        tick();

        // Round-robin burst: 6 words in each FIFO, straight out of reset
        obs_src.delete();
        for (int i = 0; i < 6; i++) begin
            push(1'b0, 8'hA0 + 8'(i));
            push(1'b1, 8'hB0 + 8'(i));
        end
        model_drain();
        wait_idle("rr_burst", 200, 1'b0);
        chk("rr_count", 32'(obs_src.size()), 32'd12);
        order = '0;
        for (int i = 0; i < 12 && i < obs_src.size(); i++) order[11 - i] = obs_src[i];
`ifdef FIFO_STRICT_PRIO_EN
        exp_order = 12'b000000_111111;
`else
        exp_order = 12'b0000_1111_0011;
`endif
        chk("rr_order", 32'(order), 32'(exp_order));

        // Single source: three words from FIFO0
        r0 = ren0_cnt; r1 = ren1_cnt;
        push(1'b0, 8'h11); push(1'b0, 8'h22); push(1'b0, 8'h33);
        model_drain();
        wait_idle("single", 100, 1'b0);
        chk("single_ren0", 32'(ren0_cnt - r0), 32'd3);
        chk("single_ren1", 32'(ren1_cnt - r1), 32'd0);

        // Backpressure: sink stalls ten cycles on 0x5A
        r0 = ren0_cnt;
        bus.OUT_READY = 1'b0;
        push(1'b0, 8'h5A);
        model_drain();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = bus.OUT_VALID;
        end
        chk("bp_valid_rise", 32'(found), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(bus.OUT_VALID), 32'd1);
            chk("bp_data", 32'(bus.OUT_DATA), 32'h5A);
            chk("bp_busy", 32'(BUSY), 32'd1);
            tick();
        end
        bus.OUT_READY = 1'b1;
        tick();
        chk("bp_idle_after", 32'(dbg_state), 32'(S_IDLE));
        chk("bp_busy_after", 32'(BUSY), 32'd0);
        chk("bp_pending", 32'(exp_q.size()), 32'd0);
        chk("bp_ren0", 32'(ren0_cnt - r0), 32'd1);

        // Reset in CAPTURE: captured word is lost, FIFO1 waits for release
        push(1'b0, 8'h3C);
        g = model_grant();
        void'(model_pop(g));
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = (dbg_state == S_CAPTURE);
        end
        chk("mid_capture_seen", 32'(found), 32'd1);
        RESET = 1'b1;
        mlast = 1'b1;
        mcnt  = 0;
        push(1'b1, 8'h4D);
        r1 = ren1_cnt;
        tick();
        chk("mid_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("mid_ren", {30'd0, bus.REN1, bus.REN0}, 32'd0);
        chk("mid_busy", 32'(BUSY), 32'd0);
        repeat (2) tick();
        chk("mid_hold_ren1", 32'(ren1_cnt - r1), 32'd0);
        chk("mid_hold_busy", 32'(BUSY), 32'd0);
        RESET = 1'b0;
        model_drain();
        wait_idle("mid_reset", 50, 1'b0);
        chk("mid_ren1_after", 32'(ren1_cnt - r1), 32'd1);

        // Gated read: FIFO0 data strobe suppressed, grant still consumed
        r0 = ren0_cnt;
        gate0 = 1'b1;
        push(1'b0, 8'h77);
        g = model_grant();
        void'(model_pop(g));
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("gate_no_valid", 32'(bus.OUT_VALID), 32'd0);
        end
        chk("gate_idle", 32'(BUSY), 32'd0);
        chk("gate_ren0", 32'(ren0_cnt - r0), 32'd1);
        gate0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 8'hC0 + 8'(i));
            push(1'b1, 8'hD0 + 8'(i));
        end
        model_drain();
        wait_idle("gate_next", 100, 1'b0);

        // Random loads with random sink backpressure
        for (int round = 0; round < 8; round++) begin
            n0 = $urandom_range(0, 7);
            n1 = $urandom_range(0, 7);
            for (int i = 0; i < n0; i++) push(1'b0, 8'($urandom_range(0, 255)));
            for (int i = 0; i < n1; i++) push(1'b1, 8'($urandom_range(0, 255)));
            model_drain();
            wait_idle("random", 400, 1'b1);
        end

        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
